instr_fetch_mem: RTL and testbench

Parametrised, clocked instruction memory that replaces the combinational `#4` ROM. It has a ready/valid fetch request/response channel with configurable read latency and a bounded in-flight count. A loader write port lets the bench or a boot block install programs at run time instead of hard-coding case tables. It sits between the PC/fetch logic and the decode stage of the processor.

---
 rtl/instr_mem_pkg.sv | 24 ++
 rtl/imem_rsp_fifo.sv | 54 +++++
 rtl/instr_fetch_mem.sv | 129 ++++++++++++
 tb/tb_instr_fetch_mem.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_pkg.sv
// Shared types and helpers for the clocked instruction memory.
// Holds the controller state encoding, default fill/fault words and address decode.
package instr_mem_pkg;

  typedef enum logic {INIT, RUN} state_e;

  localparam logic [31:0] FILL_WORD_DEF  = 32'hD503201F;
  localparam logic [31:0] FAULT_WORD_DEF = 32'h00000000;

  typedef struct packed {
    logic        fault;
    logic [11:0] idx;
  } loc_t;

  // off is the byte offset from BASE_ADDR, already wrapped to the address width.
  // Anything below base wraps high and therefore lands out of range.
  function automatic loc_t addr_loc(input logic [63:0] off, input int unsigned depth);
    loc_t r;
    r.idx   = off[13:2];
    r.fault = (off[1:0] != 2'b00) || ((off >> 2) >= 64'(depth));
    return r;
  endfunction

endpackage

// File: rtl/imem_rsp_fifo.sv
// First-word-fall-through response FIFO; the head is visible while valid_o is high.
// Output data reads as zero while empty so RspData is clean during reset.
module imem_rsp_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign valid_o = (cnt_q != '0);
  assign data_o  = valid_o ? mem_q[rptr_q] : '0;
  assign do_pop  = pop_i && valid_o;

  always_comb begin
    wptr_d = push_i ? nxt(wptr_q) : wptr_q;
    rptr_d = do_pop ? nxt(rptr_q) : rptr_q;
    cnt_d  = cnt_q + CW'(push_i) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= push_data_i;
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// Clocked instruction memory: fill sweep on reset, loader write port, and a
// ready/valid fetch channel with fixed read latency and credit-bounded in-flight count.
module instr_fetch_mem
  import instr_mem_pkg::*;
#(
  parameter int                ADDR_W     = 64,
  parameter int                DATA_W     = 32,
  parameter int                DEPTH      = 64,
  parameter logic [63:0]       BASE_ADDR  = 64'h0,
  parameter int                RD_LATENCY = 2,
  parameter int                RSP_DEPTH  = 4,
  parameter logic [DATA_W-1:0] FILL_WORD  = FILL_WORD_DEF,
  parameter logic [DATA_W-1:0] FAULT_WORD = FAULT_WORD_DEF
) (
  input  logic              CLK,
  input  logic              Reset_L,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic [ADDR_W-1:0] ReqAddr,
  output logic              RspValid,
  input  logic              RspReady,
  output logic [DATA_W-1:0] RspData,
  output logic              RspFault,
  input  logic              LdValid,
  output logic              LdReady,
  input  logic [ADDR_W-1:0] LdAddr,
  input  logic [DATA_W-1:0] LdData,
  output logic              InitDone
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic              fault;
    logic [DATA_W-1:0] data;
  } rsp_t;

  state_e            state_q, state_d;
  logic [IW-1:0]     fill_q, fill_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              mem_we;
  logic [IW-1:0]     mem_wa;
  logic [DATA_W-1:0] mem_wd;

  logic [RD_LATENCY:1] vld_pipe_q, vld_pipe_d;
  rsp_t                rsp_pipe_q [1:RD_LATENCY];
  rsp_t                rsp_pipe_d [1:RD_LATENCY];

  logic [ADDR_W-1:0] req_off, ld_off;
  loc_t              req_loc, ld_loc;
  logic              acc, pop;

  assign req_off = ReqAddr - BASE_ADDR[ADDR_W-1:0];
  assign ld_off  = LdAddr - BASE_ADDR[ADDR_W-1:0];
  assign req_loc = addr_loc(64'(req_off), DEPTH);
  assign ld_loc  = addr_loc(64'(ld_off), DEPTH);

  assign ReqReady = (state_q == RUN) && (cnt_q < CW'(RSP_DEPTH));
  assign LdReady  = (state_q == RUN);
  assign InitDone = (state_q == RUN);
  assign acc      = ReqValid && ReqReady;
  assign pop      = RspValid && RspReady;

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    mem_we  = 1'b0;
    mem_wa  = fill_q;
    mem_wd  = FILL_WORD;
    if (state_q == INIT) begin
      mem_we = 1'b1;
      fill_d = fill_q + 1'b1;
      if (fill_q == IW'(DEPTH - 1)) state_d = RUN;
    end else if (LdValid && !ld_loc.fault) begin
      mem_we = 1'b1;
      mem_wa = ld_loc.idx[IW-1:0];
      mem_wd = LdData;
    end
  end

  // The array is sampled at the accept edge, so a same-edge loader write is not seen.
  always_comb begin
    cnt_d         = cnt_q + CW'(acc) - CW'(pop);
    vld_pipe_d[1] = acc;
    rsp_pipe_d[1] = req_loc.fault ? {1'b1, FAULT_WORD}
                                  : {1'b0, mem_q[req_loc.idx[IW-1:0]]};
    for (int j = 2; j <= RD_LATENCY; j++) begin
      vld_pipe_d[j] = vld_pipe_q[j-1];
      rsp_pipe_d[j] = rsp_pipe_q[j-1];
    end
  end

  always_ff @(posedge CLK or negedge Reset_L) begin
    if (!Reset_L) begin
      state_q    <= INIT;
      fill_q     <= '0;
      cnt_q      <= '0;
      vld_pipe_q <= '0;
      for (int j = 1; j <= RD_LATENCY; j++) rsp_pipe_q[j] <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      cnt_q      <= cnt_d;
      vld_pipe_q <= vld_pipe_d;
      for (int j = 1; j <= RD_LATENCY; j++) rsp_pipe_q[j] <= rsp_pipe_d[j];
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) mem_q[mem_wa] <= mem_wd;
  end

  // Credits cover pipeline plus FIFO, so the FIFO can never overflow.
  imem_rsp_fifo #(
    .W     (DATA_W + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (CLK),
    .rst_n       (Reset_L),
    .push_i      (vld_pipe_q[RD_LATENCY]),
    .push_data_i (rsp_pipe_q[RD_LATENCY]),
    .pop_i       (pop),
    .valid_o     (RspValid),
    .data_o      ({RspFault, RspData})
  );

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Self-checking bench for instr_fetch_mem: vector table plus hand sequences,
// responses checked through an in-order scoreboard.
module tb_instr_fetch_mem;

  localparam logic [31:0] FILL = 32'hD503201F;

  logic        CLK = 1'b0;
  logic        Reset_L = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic [63:0] ReqAddr = '0;
  logic        RspValid;
  logic        RspReady = 1'b0;
  logic [31:0] RspData;
  logic        RspFault;
  logic        LdValid = 1'b0;
  logic        LdReady;
  logic [63:0] LdAddr = '0;
  logic [31:0] LdData = '0;
  logic        InitDone;

  int tests = 0;
  int fails = 0;
  logic [32:0] sb[$];

  typedef struct {
    logic [63:0] addr;
    logic        fault;
    logic [31:0] data;
  } vec_t;
  vec_t tbl[10];

  always #5 CLK = ~CLK;

  instr_fetch_mem dut (
    .CLK(CLK), .Reset_L(Reset_L),
    .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddr(ReqAddr),
    .RspValid(RspValid), .RspReady(RspReady), .RspData(RspData), .RspFault(RspFault),
    .LdValid(LdValid), .LdReady(LdReady), .LdAddr(LdAddr), .LdData(LdData),
    .InitDone(InitDone)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  always @(negedge CLK) begin
    if (Reset_L && RspValid && RspReady) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rsp_unexpected: got %h expected none", {RspFault, RspData});
      end else begin
        chk("rsp", 64'({RspFault, RspData}), 64'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic fetch(input logic [63:0] a, input logic f, input logic [31:0] d);
    int n = 0;
    ReqAddr  = a;
    ReqValid = 1'b1;
    @(negedge CLK);
    while (!ReqReady && n < 100) begin
      n++;
      @(negedge CLK);
    end
    if (!ReqReady) begin
      tests++;
      fails++;
      $display("FAIL fetch_timeout: got ReqReady=0 expected 1 for addr %h", a);
    end else begin
      sb.push_back({f, d});
    end
    tick();
    ReqValid = 1'b0;
  endtask

  task automatic load(input logic [63:0] a, input logic [31:0] d);
    LdAddr  = a;
    LdData  = d;
    LdValid = 1'b1;
    @(negedge CLK);
    chk("ld_rdy", 64'(LdReady), 64'd1);
    tick();
    LdValid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (sb.size() == 0 && !RspValid) break;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acc, k;
    logic [63:0] a2[3];
    logic [32:0] e2[3];
    logic        rv[7];
    logic [63:0] a4[6];
    logic [32:0] e4[6];

    tbl[0] = '{64'h0,   1'b0, 32'hF84003E9};
    tbl[1] = '{64'h4,   1'b0, 32'hF84083EA};
    tbl[2] = '{64'h8,   1'b0, 32'hF84103EB};
    tbl[3] = '{64'h6,   1'b1, 32'h0};
    tbl[4] = '{64'h100, 1'b1, 32'h0};
    tbl[5] = '{64'h4,   1'b0, 32'hF84083EA};
    tbl[6] = '{64'hFC,  1'b0, FILL};
    tbl[7] = '{64'h2,   1'b1, 32'h0};
    tbl[8] = '{64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 32'h0};
    tbl[9] = '{64'h1,   1'b1, 32'h0};

    // Reset values
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_reqrdy", 64'(ReqReady), 0);
    chk("rst_ldrdy", 64'(LdReady), 0);
    chk("rst_rspv", 64'(RspValid), 0);
    chk("rst_fault", 64'(RspFault), 0);
    chk("rst_data", 64'(RspData), 0);
    chk("rst_done", 64'(InitDone), 0);

    // Fill sweep length, then first fetch
    @(posedge CLK); #1;
    Reset_L = 1'b1;
    n = 0;
    @(negedge CLK);
    while (!ReqReady && n < 200) begin
      n++;
      @(negedge CLK);
    end
    chk("init_cycles", 64'(n), 64'd64);
    chk("init_done", 64'(InitDone), 1);
    chk("run_ldrdy", 64'(LdReady), 1);
    tick();
    RspReady = 1'b1;
    fetch(64'h0, 1'b0, FILL);
    drain();

    // Load then back-to-back fetches with latency check
    load(64'h0, 32'hF84003E9);
    load(64'h4, 32'hF84083EA);
    load(64'h8, 32'hF84103EB);
    a2 = '{64'h0, 64'h4, 64'h8};
    e2 = '{{1'b0, 32'hF84003E9}, {1'b0, 32'hF84083EA}, {1'b0, 32'hF84103EB}};
    rv = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      ReqValid = (i < 3);
      if (i < 3) ReqAddr = a2[i];
      @(negedge CLK);
      if (i < 3) begin
        chk("b2b_rdy", 64'(ReqReady), 1);
        sb.push_back(e2[i]);
      end
      chk("b2b_rspv", 64'(RspValid), 64'(rv[i]));
      tick();
    end
    ReqValid = 1'b0;
    drain();

    // Vector table: aligned, misaligned, out of range, below base
    foreach (tbl[i]) fetch(tbl[i].addr, tbl[i].fault, tbl[i].data);
    drain();

    // Backpressure: only RSP_DEPTH requests accepted
    a4 = '{64'h0, 64'h4, 64'h8, 64'hC, 64'h10, 64'h14};
    e4 = '{{1'b0, 32'hF84003E9}, {1'b0, 32'hF84083EA}, {1'b0, 32'hF84103EB},
           {1'b0, FILL}, {1'b0, FILL}, {1'b0, FILL}};
    RspReady = 1'b0;
    acc = 0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      ReqValid = (k < 6);
      ReqAddr  = (k < 6) ? a4[k] : 64'h0;
      @(negedge CLK);
      if (ReqValid && ReqReady) begin
        sb.push_back(e4[k]);
        acc++;
        k++;
      end
      tick();
    end
    ReqValid = 1'b0;
    @(negedge CLK);
    chk("bp_accepted", 64'(acc), 64'd4);
    chk("bp_reqrdy", 64'(ReqReady), 0);
    chk("bp_hold_v", 64'(RspValid), 1);
    chk("bp_hold_d0", 64'(RspData), 64'hF84003E9);
    tick();
    @(negedge CLK);
    chk("bp_hold_d1", 64'({RspFault, RspData}), 64'h0F84003E9);
    tick();
    RspReady = 1'b1;
    tick();
    chk("bp_reqrdy_back", 64'(ReqReady), 1);
    drain();

    // Same-edge load and fetch: old word, then new word
    ReqAddr  = 64'h14;
    ReqValid = 1'b1;
    LdAddr   = 64'h14;
    LdData   = 32'hAA0B014A;
    LdValid  = 1'b1;
    @(negedge CLK);
    chk("rbw_rdy", 64'(ReqReady), 1);
    sb.push_back({1'b0, FILL});
    tick();
    ReqValid = 1'b0;
    LdValid  = 1'b0;
    fetch(64'h14, 1'b0, 32'hAA0B014A);
    drain();

    // Dropped loader writes: misaligned and out of range
    load(64'h16, 32'h11111111);
    load(64'h200, 32'h22222222);
    fetch(64'h14, 1'b0, 32'hAA0B014A);
    fetch(64'h0, 1'b0, 32'hF84003E9);
    drain();

    // Reset with responses pending
    RspReady = 1'b0;
    fetch(64'h0, 1'b0, 32'hF84003E9);
    fetch(64'h4, 1'b0, 32'hF84083EA);
    fetch(64'h8, 1'b0, 32'hF84103EB);
    repeat (3) tick();
    chk("pend_rspv", 64'(RspValid), 1);
    Reset_L = 1'b0;
    #1;
    chk("arst_rspv", 64'(RspValid), 0);
    chk("arst_reqrdy", 64'(ReqReady), 0);
    sb.delete();
    repeat (2) tick();
    Reset_L  = 1'b1;
    RspReady = 1'b1;
    fetch(64'h0, 1'b0, FILL);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
